// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a length/data/checksum byte frame,
// writes words through the data port and releases the core on success.
module prog_loader #(
  parameter int          MEM_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               dwe,
  output logic [31:0]        daddr,
  output logic [31:0]        ddatain,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MEM_WIDTH:0] words_written,
  output logic               core_rst
);

  localparam int CW = MEM_WIDTH + 1;
  localparam logic [32:0]   LIMIT = 33'd1 << MEM_WIDTH;
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CSUM, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;
  logic [23:0]   acc, acc_n, acc_ins;
  logic [CW-1:0] len, len_n, ww_n;
  logic [7:0]    csum, csum_n;
  logic          dwe_n;
  logic [31:0]   daddr_n, ddatain_n;
  logic          take;
  logic [31:0]   word;

  assign take = in_valid && in_ready;
  // The 4th byte completes a value; the low three are already in acc.
  assign word = {in_data, acc};

  always_comb begin
    acc_ins = acc;
    unique case (cnt)
      2'd0:    acc_ins[7:0]   = in_data;
      2'd1:    acc_ins[15:8]  = in_data;
      2'd2:    acc_ins[23:16] = in_data;
      default: acc_ins        = acc;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_n     = acc;
    len_n     = len;
    ww_n      = words_written;
    csum_n    = csum;
    dwe_n     = 1'b0;
    daddr_n   = daddr;
    ddatain_n = ddatain;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = LEN;
          cnt_n   = 2'd0;
          acc_n   = 24'd0;
          len_n   = '0;
          ww_n    = '0;
          csum_n  = 8'd0;
        end
      end
      LEN: begin
        if (take) begin
          cnt_n = cnt + 2'd1;
          acc_n = acc_ins;
          if (cnt == 2'd3) begin
            if (word == 32'd0) begin
              state_n = CSUM;
            end else if ({1'b0, word} > LIMIT) begin
              state_n = ERR;
            end else begin
              len_n   = word[CW-1:0];
              state_n = DATA;
            end
          end
        end
      end
      DATA: begin
        if (take) begin
          cnt_n  = cnt + 2'd1;
          acc_n  = acc_ins;
          csum_n = csum ^ in_data;
          if (cnt == 2'd3) begin
            dwe_n     = 1'b1;
            daddr_n   = BASE_ADDR + 32'(words_written);
            ddatain_n = word;
            ww_n      = words_written + ONE;
            if (ww_n == len) state_n = CSUM;
          end
        end
      end
      CSUM: begin
        if (take) state_n = (in_data == csum) ? DONE : ERR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      acc           <= 24'd0;
      len           <= '0;
      csum          <= 8'd0;
      words_written <= '0;
      dwe           <= 1'b0;
      daddr         <= 32'd0;
      ddatain       <= 32'd0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      core_rst      <= 1'b1;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      acc           <= acc_n;
      len           <= len_n;
      csum          <= csum_n;
      words_written <= ww_n;
      dwe           <= dwe_n;
      daddr         <= daddr_n;
      ddatain       <= ddatain_n;
      // Status outputs are a registered decode of the next state.
      in_ready      <= state_n inside {LEN, DATA, CSUM};
      busy          <= state_n inside {LEN, DATA, CSUM};
      done          <= state_n == DONE;
      err           <= state_n == ERR;
      core_rst      <= state_n != DONE;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued
// as frames are driven and popped when dwe pulses.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, dwe, busy, done, err, core_rst;
  logic [31:0] daddr, ddatain;
  logic [16:0] words_written;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[0:1];
  logic        dwe_q = 1'b0;

  prog_loader #(.MEM_WIDTH(16), .BASE_ADDR(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dwe(dwe), .daddr(daddr), .ddatain(ddatain),
    .busy(busy), .done(done), .err(err),
    .words_written(words_written), .core_rst(core_rst)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [63:0] e;
    if (dwe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got=%h/%h want=none", daddr, ddatain);
      end else begin
        e = exp_q.pop_front();
        if ({daddr, ddatain} !== e) begin
          failures++;
          $display("FAIL write got=%h/%h want=%h/%h",
                   daddr, ddatain, e[63:32], e[31:0]);
        end
      end
      checks++;
      if (dwe_q) begin
        failures++;
        $display("FAIL dwe_pulse got=2+cycles want=1");
      end
    end
    dwe_q = dwe;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1, "timeout");
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    int gap;
    gap = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
    for (int i = 0; i < gap; i++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input int gapmax);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gapmax);
  endtask

  task automatic send_data(input int nbytes, input int gapmax);
    logic [31:0] w;
    for (int k = 0; k < nbytes; k++) begin
      w = img[k/4];
      if (k % 4 == 3) exp_q.push_back({32'(k/4), w});
      send_byte(w[8*(k%4) +: 8], gapmax);
    end
  endtask

  task automatic check_end(input string nm, input logic d,
                           input logic e, input int ww);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, err, core_rst, busy} !== {d, e, ~d, 1'b0}) begin
      failures++;
      $display("FAIL %s_status got=d%b e%b c%b b%b want=d%b e%b c%b b0",
               nm, done, err, core_rst, busy, d, e, ~d);
    end
    checks++;
    if (words_written !== 17'(ww)) begin
      failures++;
      $display("FAIL %s_words got=%0d want=%0d", nm, words_written, ww);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d want=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, dwe, busy, done, err, core_rst, daddr, ddatain,
         words_written} !== {5'b0, 1'b1, 64'b0, 17'b0}) begin
      failures++;
      $display("FAIL reset got=%b%b%b%b%b%b %h %h %h want=000001 0 0 0",
               in_ready, dwe, busy, done, err, core_rst,
               daddr, ddatain, words_written);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle_byte();
    @(negedge clk); in_valid = 1'b1; in_data = 8'hff;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      failures++;
      $display("FAIL idle_byte got=%b%b want=00", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start();
    send_len(32'd2, 0);
    send_data(8, 0);
    send_byte(8'h90, 0);
    check_end("basic", 1'b1, 1'b0, 2);
    checks++;
    if ({daddr, ddatain} !== {32'd1, 32'h0010_0093}) begin
      failures++;
      $display("FAIL basic_hold got=%h/%h want=1/00100093", daddr, ddatain);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    checks++;
    if ({core_rst, done, busy} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_restart got=%b%b%b want=101", core_rst, done, busy);
    end
    send_len(32'd0, 0);
    send_byte(8'h00, 0);
    check_end("zero_len", 1'b1, 1'b0, 0);
  endtask

  task automatic test_bad_csum();
    do_start();
    send_len(32'd2, 0);
    send_data(8, 0);
    send_byte(8'h91, 0);
    check_end("bad_csum", 1'b0, 1'b1, 2);
  endtask

  task automatic test_len_overflow();
    do_start();
    send_len(32'h0001_0001, 0);
    checks++;
    if ({err, done, in_ready, core_rst} !== 4'b1001) begin
      failures++;
      $display("FAIL len_ovf got=%b%b%b%b want=1001",
               err, done, in_ready, core_rst);
    end
    check_end("len_ovf", 1'b0, 1'b1, 0);
  endtask

  task automatic test_gaps();
    do_start();
    send_len(32'd2, 5);
    do_start();
    send_data(8, 5);
    send_byte(8'h90, 5);
    check_end("gaps", 1'b1, 1'b0, 2);
  endtask

  task automatic test_rst_mid();
    do_start();
    send_len(32'd2, 0);
    send_data(6, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, dwe, busy, done, err, core_rst, daddr, ddatain,
         words_written} !== {5'b0, 1'b1, 64'b0, 17'b0}) begin
      failures++;
      $display("FAIL rst_mid got=%b%b%b%b%b%b %h %h %h want=000001 0 0 0",
               in_ready, dwe, busy, done, err, core_rst,
               daddr, ddatain, words_written);
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, core_rst, words_written} !== {2'b01, 17'd0}) begin
      failures++;
      $display("FAIL rst_idle got=%b%b %0d want=01 0",
               busy, core_rst, words_written);
    end
    do_start();
    send_len(32'd2, 0);
    send_data(8, 0);
    send_byte(8'h90, 0);
    check_end("rst_restart", 1'b1, 1'b0, 2);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    test_reset();
    test_idle_byte();
    test_basic();
    test_back_to_back();
    test_bad_csum();
    test_len_overflow();
    test_gaps();
    test_rst_mid();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
